effects_ctrl: RTL and testbench

EFFECTS_CTRL -- requirements
Module: effects_ctrl

---
 rtl/effects_ctrl_if.sv | 9 +
 rtl/effects_ctrl.sv | 93 +++++++++
 tb/tb_effects_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/effects_ctrl_if.sv
// effects_ctrl_if: config request handshake (valid/ready with address and data).
interface effects_ctrl_if;
   logic       vld;
   logic       rdy;
   logic [1:0] addr;
   logic [9:0] data;
   modport master(output vld, addr, data, input rdy);
   modport slave(input vld, addr, data, output rdy);
endinterface

// File: rtl/effects_ctrl.sv
// effects_ctrl: strobe-paced gain/bypass controller with one-deep request buffer.
// Define EFFECTS_CTRL_RAMP_EN for stepped gain ramps and fade-out/fade-in bypass switching.
module effects_ctrl #(
   parameter logic [9:0] GAIN_DEFAULT = 10'd20,
   parameter logic [5:0] STEP_DEFAULT = 6'd1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_strobe,
   effects_ctrl_if.slave        cfg,
   output logic [9:0]           gain_value,
   output logic                 bypass,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, RAMP, FADE_DOWN, SWITCH, FADE_UP} state_t;
   state_t state, state_n;
   logic [9:0] gain_n, target, target_n, pend_data;
   logic [1:0] pend_addr;
   logic pend_vld, bypass_n, accept, apply;
   assign cfg.rdy = ~pend_vld & ~rst;
   assign accept = cfg.vld & cfg.rdy;
   // requests wait out a fade so bypass switching is never interrupted
   assign apply = sample_strobe & pend_vld & (state == IDLE || state == RAMP);
   assign busy = (state != IDLE) | pend_vld;
`ifdef EFFECTS_CTRL_RAMP_EN
   logic [5:0] step, step_n;
   logic [9:0] diff, ramp_gain, down_gain;
   logic fade_req;
   always_comb begin
      diff = target > gain_value ? target - gain_value : gain_value - target;
      ramp_gain = diff <= {4'd0, step} ? target :
                  target > gain_value ? gain_value + {4'd0, step} : gain_value - {4'd0, step};
      down_gain = gain_value <= {4'd0, step} ? 10'd0 : gain_value - {4'd0, step};
      target_n = apply && pend_addr == 2'd0 ? pend_data : target;
      step_n = apply && pend_addr == 2'd2 ? (pend_data[5:0] == 6'd0 ? 6'd1 : pend_data[5:0]) : step;
      fade_req = apply && pend_addr == 2'd1 && pend_data[0] != bypass;
      state_n = state;
      gain_n = gain_value;
      bypass_n = bypass;
      if (sample_strobe)
         case (state)
            IDLE: state_n = fade_req ? FADE_DOWN : gain_value != target_n ? RAMP : IDLE;
            RAMP: begin
               gain_n = ramp_gain;
               state_n = fade_req ? FADE_DOWN : ramp_gain != target_n ? RAMP : IDLE;
            end
            FADE_DOWN: begin
               gain_n = down_gain;
               state_n = down_gain == 10'd0 ? SWITCH : FADE_DOWN;
            end
            SWITCH: begin
               bypass_n = ~bypass;
               state_n = FADE_UP;
            end
            FADE_UP: begin
               gain_n = ramp_gain;
               state_n = ramp_gain == target ? IDLE : FADE_UP;
            end
            default: state_n = IDLE;
         endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) step <= STEP_DEFAULT;
      else step <= step_n;
`else
   always_comb begin
      target_n = apply && pend_addr == 2'd0 ? pend_data : target;
      gain_n = apply && pend_addr == 2'd0 ? pend_data : gain_value;
      bypass_n = apply && pend_addr == 2'd1 ? pend_data[0] : bypass;
      state_n = IDLE;
   end
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         gain_value <= GAIN_DEFAULT;
         target <= GAIN_DEFAULT;
         bypass <= 1'b0;
         pend_vld <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
      end else begin
         state <= state_n;
         gain_value <= gain_n;
         target <= target_n;
         bypass <= bypass_n;
         pend_vld <= accept | (pend_vld & ~apply);
         if (accept) begin
            pend_addr <= cfg.addr;
            pend_data <= cfg.data;
         end
      end
endmodule

// File: tb/tb_effects_ctrl.sv
// tb_effects_ctrl: directed checks of effects_ctrl; covers both EFFECTS_CTRL_RAMP_EN builds.
module tb_effects_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sample_strobe = 1'b0;
   logic [9:0] gain_value;
   logic bypass, busy;
   int passed = 0;
   int total = 0;
   effects_ctrl_if cfg();
   effects_ctrl dut(.clk(clk), .rst(rst), .sample_strobe(sample_strobe), .cfg(cfg),
                    .gain_value(gain_value), .bypass(bypass), .busy(busy));
   always #5 clk = ~clk;

   task automatic strobe();
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
   endtask

   task automatic write(input logic [1:0] a, input logic [9:0] d);
      int n = 0;
      cfg.vld = 1'b1;
      cfg.addr = a;
      cfg.data = d;
      while (!cfg.rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (cfg.rdy !== 1'b1) $display("FAIL write_accept rdy=%b want 1", cfg.rdy); else passed++;
      @(negedge clk);
      cfg.vld = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg.vld = 1'b0;
      cfg.addr = '0;
      cfg.data = '0;
      repeat (2) @(negedge clk);
      total++; if (gain_value !== 10'd20) $display("FAIL reset_gain got %0d want 20", gain_value); else passed++;
      total++; if (bypass !== 1'b0) $display("FAIL reset_bypass got %b want 0", bypass); else passed++;
      total++; if (cfg.rdy !== 1'b0) $display("FAIL reset_rdy got %b want 0", cfg.rdy); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      rst = 1'b0;
      @(negedge clk);
      total++; if (cfg.rdy !== 1'b1) $display("FAIL reset_rdy_after got %b want 1", cfg.rdy); else passed++;
   endtask

`ifdef EFFECTS_CTRL_RAMP_EN
   task automatic test_ramp_up();
      logic [9:0] exp [3] = '{10'd24, 10'd28, 10'd30};
      write(2'd2, 10'd4);
      strobe();
      write(2'd0, 10'd30);
      strobe();
      total++; if (gain_value !== 10'd20) $display("FAIL ramp_apply got %0d want 20", gain_value); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL ramp_busy got %b want 1", busy); else passed++;
      for (int i = 0; i < 3; i++) begin
         strobe();
         total++; if (gain_value !== exp[i]) $display("FAIL ramp_step%0d got %0d want %0d", i, gain_value, exp[i]); else passed++;
      end
      total++; if (busy !== 1'b0) $display("FAIL ramp_done_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_bypass_fade();
      logic [9:0] exp [8] = '{10'd15, 10'd10, 10'd5, 10'd0, 10'd5, 10'd10, 10'd15, 10'd20};
      int n = 0;
      write(2'd0, 10'd20);
      strobe();
      while (busy && n < 20) begin
         strobe();
         n++;
      end
      total++; if (gain_value !== 10'd20) $display("FAIL fade_setup got %0d want 20", gain_value); else passed++;
      write(2'd2, 10'd5);
      strobe();
      write(2'd1, 10'd1);
      strobe();
      total++; if (gain_value !== 10'd20) $display("FAIL fade_apply got %0d want 20", gain_value); else passed++;
      for (int i = 0; i < 4; i++) begin
         strobe();
         total++; if (gain_value !== exp[i]) $display("FAIL fade_down%0d got %0d want %0d", i, gain_value, exp[i]); else passed++;
      end
      total++; if (bypass !== 1'b0) $display("FAIL fade_bypass_early got %b want 0", bypass); else passed++;
      strobe();
      total++; if (bypass !== 1'b1) $display("FAIL fade_switch got %b want 1", bypass); else passed++;
      for (int i = 4; i < 8; i++) begin
         strobe();
         total++; if (gain_value !== exp[i]) $display("FAIL fade_up%0d got %0d want %0d", i, gain_value, exp[i]); else passed++;
      end
      total++; if (busy !== 1'b0) $display("FAIL fade_done_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_boundaries();
      logic [9:0] exp [3] = '{10'd21, 10'd22, 10'd23};
      int n = 0;
      write(2'd2, 10'd0);
      strobe();
      write(2'd0, 10'd23);
      strobe();
      for (int i = 0; i < 3; i++) begin
         strobe();
         total++; if (gain_value !== exp[i]) $display("FAIL step0_%0d got %0d want %0d", i, gain_value, exp[i]); else passed++;
      end
      write(2'd2, 10'd63);
      strobe();
      write(2'd0, 10'd1020);
      strobe();
      while (busy && n < 40) begin
         strobe();
         n++;
      end
      total++; if (gain_value !== 10'd1020) $display("FAIL ramp_1020 got %0d want 1020", gain_value); else passed++;
      write(2'd0, 10'd1023);
      strobe();
      strobe();
      total++; if (gain_value !== 10'd1023) $display("FAIL top_sat got %0d want 1023", gain_value); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL top_busy got %b want 0", busy); else passed++;
      write(2'd3, 10'd5);
      strobe();
      total++; if (gain_value !== 10'd1023) $display("FAIL addr3_gain got %0d want 1023", gain_value); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL addr3_busy got %b want 0", busy); else passed++;
      total++; if (cfg.rdy !== 1'b1) $display("FAIL addr3_rdy got %b want 1", cfg.rdy); else passed++;
   endtask
`else
   task automatic test_direct_gain();
      write(2'd0, 10'd200);
      total++; if (gain_value !== 10'd20) $display("FAIL direct_hold got %0d want 20", gain_value); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL direct_pend_busy got %b want 1", busy); else passed++;
      strobe();
      total++; if (gain_value !== 10'd200) $display("FAIL direct_gain got %0d want 200", gain_value); else passed++;
      @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL direct_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_coincide();
      cfg.vld = 1'b1;
      cfg.addr = 2'd0;
      cfg.data = 10'd300;
      sample_strobe = 1'b1;
      @(negedge clk);
      cfg.vld = 1'b0;
      sample_strobe = 1'b0;
      total++; if (gain_value !== 10'd200) $display("FAIL coincide_hold got %0d want 200", gain_value); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL coincide_busy got %b want 1", busy); else passed++;
      strobe();
      total++; if (gain_value !== 10'd300) $display("FAIL coincide_apply got %0d want 300", gain_value); else passed++;
   endtask

   task automatic test_bypass_direct();
      write(2'd1, 10'd1);
      strobe();
      total++; if (bypass !== 1'b1) $display("FAIL bypass_set got %b want 1", bypass); else passed++;
      total++; if (gain_value !== 10'd300) $display("FAIL bypass_gain got %0d want 300", gain_value); else passed++;
      write(2'd1, 10'd1);
      strobe();
      total++; if (bypass !== 1'b1) $display("FAIL bypass_same got %b want 1", bypass); else passed++;
      write(2'd1, 10'd0);
      strobe();
      total++; if (bypass !== 1'b0) $display("FAIL bypass_clear got %b want 0", bypass); else passed++;
   endtask

   task automatic test_no_strobe();
      write(2'd0, 10'd5);
      repeat (3) @(negedge clk);
      total++; if (gain_value !== 10'd300) $display("FAIL nostrobe_gain got %0d want 300", gain_value); else passed++;
      total++; if (cfg.rdy !== 1'b0) $display("FAIL nostrobe_rdy got %b want 0", cfg.rdy); else passed++;
      strobe();
      total++; if (gain_value !== 10'd5) $display("FAIL nostrobe_apply got %0d want 5", gain_value); else passed++;
   endtask

   task automatic test_discard();
      write(2'd2, 10'd7);
      strobe();
      total++; if (gain_value !== 10'd5) $display("FAIL addr2_gain got %0d want 5", gain_value); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL addr2_busy got %b want 0", busy); else passed++;
      write(2'd3, 10'd9);
      strobe();
      total++; if (gain_value !== 10'd5) $display("FAIL addr3_gain got %0d want 5", gain_value); else passed++;
      total++; if (bypass !== 1'b0) $display("FAIL addr3_bypass got %b want 0", bypass); else passed++;
      total++; if (cfg.rdy !== 1'b1) $display("FAIL addr3_rdy got %b want 1", cfg.rdy); else passed++;
   endtask
`endif

   task automatic test_reset_mid();
`ifdef EFFECTS_CTRL_RAMP_EN
      write(2'd0, 10'd500);
      strobe();
      strobe();
      total++; if (gain_value !== 10'd960) $display("FAIL midramp_gain got %0d want 960", gain_value); else passed++;
`else
      write(2'd1, 10'd1);
      strobe();
      total++; if (bypass !== 1'b1) $display("FAIL premid_bypass got %b want 1", bypass); else passed++;
`endif
      rst = 1'b1;
      #1;
      total++; if (gain_value !== 10'd20) $display("FAIL rstmid_gain got %0d want 20", gain_value); else passed++;
      total++; if (bypass !== 1'b0) $display("FAIL rstmid_bypass got %b want 0", bypass); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
      total++; if (cfg.rdy !== 1'b0) $display("FAIL rstmid_rdy got %b want 0", cfg.rdy); else passed++;
      @(negedge clk);
      strobe();
      total++; if (gain_value !== 10'd20) $display("FAIL rstmid_strobe got %0d want 20", gain_value); else passed++;
      rst = 1'b0;
      @(negedge clk);
      strobe();
      total++; if (gain_value !== 10'd20) $display("FAIL rstmid_after got %0d want 20", gain_value); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rstmid_after_busy got %b want 0", busy); else passed++;
      total++; if (cfg.rdy !== 1'b1) $display("FAIL rstmid_after_rdy got %b want 1", cfg.rdy); else passed++;
   endtask

   task automatic test_back_to_back();
      int n = 0;
      write(2'd0, 10'd100);
      cfg.vld = 1'b1;
      cfg.addr = 2'd0;
      cfg.data = 10'd50;
      repeat (2) begin
         @(negedge clk);
         total++; if (cfg.rdy !== 1'b0) $display("FAIL b2b_hold_rdy got %b want 0", cfg.rdy); else passed++;
      end
      strobe();
`ifdef EFFECTS_CTRL_RAMP_EN
      total++; if (gain_value !== 10'd20) $display("FAIL b2b_first got %0d want 20", gain_value); else passed++;
`else
      total++; if (gain_value !== 10'd100) $display("FAIL b2b_first got %0d want 100", gain_value); else passed++;
`endif
      total++; if (cfg.rdy !== 1'b1) $display("FAIL b2b_rdy_open got %b want 1", cfg.rdy); else passed++;
      @(negedge clk);
      cfg.vld = 1'b0;
      total++; if (cfg.rdy !== 1'b0) $display("FAIL b2b_second_taken got %b want 0", cfg.rdy); else passed++;
      strobe();
`ifdef EFFECTS_CTRL_RAMP_EN
      total++; if (gain_value !== 10'd21) $display("FAIL b2b_retarget got %0d want 21", gain_value); else passed++;
`endif
      while (busy && n < 100) begin
         strobe();
         n++;
      end
      total++; if (gain_value !== 10'd50) $display("FAIL b2b_final got %0d want 50", gain_value); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL b2b_busy got %b want 0", busy); else passed++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
`ifdef EFFECTS_CTRL_RAMP_EN
      test_ramp_up();
      test_bypass_fade();
      test_boundaries();
`else
      test_direct_gain();
      test_coincide();
      test_bypass_direct();
      test_no_strobe();
      test_discard();
`endif
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
